// File: rtl/stream_msg_fifo.sv
// Skid-buffered valid/ready stream stage and an independent show-ahead message FIFO.
// Stream: 1-cycle latency, full throughput, ready_out drops only once the skid word is held.
module stream_msg_fifo #(
  parameter int DATA_WIDTH = 26,
  parameter int MSG_WIDTH  = 32,
  parameter int ADDR_W     = 8
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  ready_out,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  ready_in,

  input  logic [MSG_WIDTH-1:0]  fifo_data,
  input  logic                  fifo_wrreq,
  input  logic                  fifo_rdreq,
  input  logic                  fifo_sclr,
  output logic [MSG_WIDTH-1:0]  fifo_q,
  output logic [ADDR_W-1:0]     fifo_usedw,
  output logic                  fifo_empty,
  output logic                  fifo_full
);

  // ---------------- stream stage ----------------
  logic                  main_vld;
  logic                  skid_vld;
  logic [DATA_WIDTH-1:0] main_dat;
  logic [DATA_WIDTH-1:0] skid_dat;
  logic                  main_take;
  logic                  in_fire;

  assign main_take = ~main_vld | ready_in;
  assign in_fire   = valid_in & ~skid_vld;

  // The skid register is only ever filled while main is full, so main is
  // always the older word and refilling from skid preserves order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      main_dat <= '0;
      skid_dat <= '0;
    end else if (main_take) begin
      if (skid_vld) begin
        main_vld <= 1'b1;
        main_dat <= skid_dat;
        skid_vld <= 1'b0;
      end else begin
        main_vld <= valid_in;
        if (valid_in)
          main_dat <= data_in;
      end
    end else if (in_fire) begin
      skid_vld <= 1'b1;
      skid_dat <= data_in;
    end
  end

  assign ready_out = ~skid_vld;
  assign valid_out = main_vld;
  assign data_out  = main_dat;

  // ---------------- message FIFO ----------------
  localparam int DEPTH = 1 << ADDR_W;

  logic [MSG_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]    wr_ptr;
  logic [ADDR_W-1:0]    rd_ptr;
  logic [ADDR_W-1:0]    used;
  logic                 wr_ok;
  logic                 rd_ok;

  assign fifo_empty = (used == '0);
  assign fifo_full  = (used == {ADDR_W{1'b1}});
  assign wr_ok      = fifo_wrreq & ~fifo_full  & ~fifo_sclr;
  assign rd_ok      = fifo_rdreq & ~fifo_empty & ~fifo_sclr;

  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[wr_ptr] <= fifo_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
    end else if (fifo_sclr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
    end else begin
      if (wr_ok)
        wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_ok)
        rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({wr_ok, rd_ok})
        2'b10:   used <= used + ADDR_W'(1);
        2'b01:   used <= used - ADDR_W'(1);
        default: used <= used;
      endcase
    end
  end

  assign fifo_q     = mem[rd_ptr];
  assign fifo_usedw = used;

endmodule

// File: tb/tb_stream_msg_fifo.sv
// Directed plus randomized bench for stream_msg_fifo, checked against queue-based models.
module tb_stream_msg_fifo;

  localparam int DW = 26;
  localparam int MW = 32;
  localparam int AW = 8;
  localparam int CAP = 255;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          valid_in = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          ready_out;
  logic          valid_out;
  logic [DW-1:0] data_out;
  logic          ready_in = 1'b0;
  logic [MW-1:0] fifo_data = '0;
  logic          fifo_wrreq = 1'b0;
  logic          fifo_rdreq = 1'b0;
  logic          fifo_sclr = 1'b0;
  logic [MW-1:0] fifo_q;
  logic [AW-1:0] fifo_usedw;
  logic          fifo_empty;
  logic          fifo_full;

  int checks = 0;
  int passes = 0;

  // Models: words held by the stream stage (at most 2) and words held by the FIFO.
  logic [DW-1:0] sq[$];
  logic [MW-1:0] fq[$];

  stream_msg_fifo #(.DATA_WIDTH(DW), .MSG_WIDTH(MW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .valid_in(valid_in), .data_in(data_in), .ready_out(ready_out),
    .valid_out(valid_out), .data_out(data_out), .ready_in(ready_in),
    .fifo_data(fifo_data), .fifo_wrreq(fifo_wrreq), .fifo_rdreq(fifo_rdreq),
    .fifo_sclr(fifo_sclr), .fifo_q(fifo_q), .fifo_usedw(fifo_usedw),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Called at a negedge: compare outputs with the models, drive the next
  // inputs, advance the models by what the coming edge will do.
  task automatic step(input logic vi, input logic [DW-1:0] di, input logic ri,
                      input logic wr, input logic [MW-1:0] wd, input logic rd,
                      input logic sc);
    int  ssz;
    int  fsz;
    ssz = sq.size();
    fsz = fq.size();
    check("valid_out", 64'(valid_out), 64'(ssz != 0));
    check("ready_out", 64'(ready_out), 64'(ssz < 2));
    if (ssz != 0) check("data_out", 64'(data_out), 64'(sq[0]));
    check("usedw", 64'(fifo_usedw), 64'(fsz));
    check("empty", 64'(fifo_empty), 64'(fsz == 0));
    check("full", 64'(fifo_full), 64'(fsz == CAP));
    if (fsz != 0) check("fifo_q", 64'(fifo_q), 64'(fq[0]));

    valid_in = vi; data_in = di; ready_in = ri;
    fifo_wrreq = wr; fifo_data = wd; fifo_rdreq = rd; fifo_sclr = sc;

    if (ssz != 0 && ri) void'(sq.pop_front());
    if (vi && ssz < 2) sq.push_back(di);
    if (sc) fq.delete();
    else begin
      if (rd && fsz != 0) void'(fq.pop_front());
      if (wr && fsz < CAP) fq.push_back(wd);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic fwrite(input logic [MW-1:0] w);
    step(1'b0, '0, 1'b1, 1'b1, w, 1'b0, 1'b0);
  endtask

  task automatic fread();
    step(1'b0, '0, 1'b1, 1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst valid_out", 64'(valid_out), 64'd0);
    check("rst ready_out", 64'(ready_out), 64'd1);
    check("rst usedw", 64'(fifo_usedw), 64'd0);
    check("rst empty", 64'(fifo_empty), 64'd1);
    check("rst full", 64'(fifo_full), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Stream pass-through
    for (int i = 1; i <= 5; i++) step(1'b1, DW'(i), 1'b1, 1'b0, '0, 1'b0, 1'b0);
    check("pass data5", 64'(data_out), 64'd5);
    check("pass ready", 64'(ready_out), 64'd1);
    idle(2);

    // Stream stall: A to main, B to skid
    step(1'b1, 26'h0AAAAAA, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 26'h0BBBBBB, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    check("stall ready", 64'(ready_out), 64'd0);
    check("stall hold A", 64'(data_out), 64'h0AAAAAA);
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    check("stall stable A", 64'(data_out), 64'h0AAAAAA);
    step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    check("drain B", 64'(data_out), 64'h0BBBBBB);
    check("drain ready", 64'(ready_out), 64'd1);
    idle(2);

    // FIFO ordering
    fwrite(32'h00524242);
    check("q first", 64'(fifo_q), 64'h00524242);
    fwrite(32'h0801027F);
    fwrite(32'h10000010);
    check("usedw 3", 64'(fifo_usedw), 64'd3);
    repeat (3) fread();
    check("order empty", 64'(fifo_empty), 64'd1);

    // FIFO full boundary: 256 writes, last is dropped
    for (int i = 0; i < 256; i++) fwrite(MW'(i));
    check("full usedw", 64'(fifo_usedw), 64'd255);
    check("full flag", 64'(fifo_full), 64'd1);
    for (int i = 0; i < 255; i++) begin
      check("full drain q", 64'(fifo_q), 64'(i));
      fread();
    end
    check("full drained", 64'(fifo_empty), 64'd1);

    // Simultaneous read+write at usedw = 5, then read on empty
    for (int i = 0; i < 5; i++) fwrite(32'hC0DE0000 + MW'(i));
    step(1'b0, '0, 1'b1, 1'b1, 32'hC0DE0005, 1'b1, 1'b0);
    check("rw usedw", 64'(fifo_usedw), 64'd5);
    check("rw q", 64'(fifo_q), 64'hC0DE0001);
    repeat (5) fread();
    fread();
    check("rd empty usedw", 64'(fifo_usedw), 64'd0);

    // sclr beats wrreq
    for (int i = 0; i < 10; i++) fwrite(MW'(100 + i));
    step(1'b0, '0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1);
    check("sclr usedw", 64'(fifo_usedw), 64'd0);
    check("sclr empty", 64'(fifo_empty), 64'd1);
    idle(1);

    // Randomized, fill-biased then balanced
    for (int i = 0; i < 700; i++)
      step(($urandom % 4) != 0, DW'($urandom), ($urandom % 3) == 0,
           ($urandom % 4) != 0, $urandom, ($urandom % 4) == 0, ($urandom % 512) == 0);
    for (int i = 0; i < 1500; i++)
      step(($urandom % 4) != 0, DW'($urandom), ($urandom % 3) != 0,
           ($urandom % 2) == 0, $urandom, ($urandom % 2) == 0, ($urandom % 128) == 0);

    // Async reset mid-stall
    idle(3);
    step(1'b1, 26'h0123456, 1'b0, 1'b1, 32'h1, 1'b0, 1'b0);
    step(1'b1, 26'h0654321, 1'b0, 1'b1, 32'h2, 1'b0, 1'b0);
    check("pre-rst ready", 64'(ready_out), 64'd0);
    #2 reset = 1'b1;
    #1;
    check("async valid_out", 64'(valid_out), 64'd0);
    check("async ready_out", 64'(ready_out), 64'd1);
    check("async usedw", 64'(fifo_usedw), 64'd0);
    sq.delete();
    fq.delete();
    valid_in = 1'b0; fifo_wrreq = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 200; i++)
      step(($urandom % 2) == 0, DW'($urandom), ($urandom % 2) == 0,
           ($urandom % 2) == 0, $urandom, ($urandom % 2) == 0, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/stream_msg_fifo.md
Name: stream_msg_fifo

Overview:
- Pairs two independent datapath primitives behind one clock and reset. Neither side interacts with the other.
- Stream side: a one-stage valid/ready pipeline register with skid buffering. It carries pixel/sop/eop words between video processing stages.
- Message side: a synchronous show-ahead FIFO that buffers 32-bit message words from a producer FSM for CPU reads over a memory-mapped port.

Parameters:
- DATA_WIDTH, 26, width of the stream payload (24-bit RGB + sop + eop).
- MSG_WIDTH, 32, width of a FIFO word.
- ADDR_W, 8, FIFO address bits; capacity = 2^ADDR_W - 1 = 255 words.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- valid_in  in  1  upstream word valid.
- data_in  in  DATA_WIDTH  upstream payload.
- ready_out  out  1  stage can accept a word (to upstream).
- valid_out  out  1  downstream word valid.
- data_out  out  DATA_WIDTH  downstream payload.
- ready_in  in  1  downstream accepts the word.
- fifo_data  in  MSG_WIDTH  word to write.
- fifo_wrreq  in  1  write request.
- fifo_rdreq  in  1  read acknowledge (pops the head word).
- fifo_sclr  in  1  synchronous clear.
- fifo_q  out  MSG_WIDTH  head word (show-ahead).
- fifo_usedw  out  ADDR_W  words currently stored.
- fifo_empty  out  1  usedw == 0.
- fifo_full  out  1  usedw == 2^ADDR_W - 1.

Behaviour:
Reset (asynchronous, any time, including mid-transfer):
- valid_out = 0, ready_out = 1, skid buffer empty.
- FIFO pointers = 0, usedw = 0, empty = 1, full = 0.
- fifo_q contents are don't-care.

Stream register:
- Input handshake: a transfer occurs on a rising edge with valid_in & ready_out. Output handshake: valid_out & ready_in.
- Holds a main register plus one skid register. ready_out is registered and equals "skid register empty".
- Input accepted while the main register is empty or draining (ready_in = 1): the word goes to the main register.
- Input accepted while the main register is full and stalled: the word goes to the skid register, and ready_out drops on the next cycle.
- When the main register drains and the skid register is full: the skid word moves to main, and ready_out returns to 1.
- Latency: data_out/valid_out reflect an accepted word 1 cycle after acceptance.
- Throughput: full throughput with no bubbles while ready_in is held at 1.
- Order is strictly preserved; no word is dropped or duplicated.
- While valid_out = 1 and ready_in = 0, data_out and valid_out are held stable.
- data_in is ignored when valid_in = 0.

Message FIFO:
- Show-ahead: when empty = 0, fifo_q presents the oldest word combinationally from storage. fifo_rdreq pops it, and the next word appears the cycle after the pop.
- Write: fifo_wrreq & ~full stores fifo_data at the tail; usedw increments. A write while full is ignored (data dropped, no change).
- Read: fifo_rdreq & ~empty advances the head; usedw decrements. A read while empty is ignored.
- Simultaneous valid read and write: both pointers advance and usedw is unchanged. When full, the read is accepted and the write is ignored.
- A write into an empty FIFO becomes visible on fifo_q and clears empty on the next cycle.
- fifo_sclr: on the next edge, pointers and usedw = 0 and empty = 1. It overrides wrreq/rdreq in the same cycle.
- usedw, empty and full are registered or derived from registered pointers; they are valid the cycle after each operation.
- Pointers wrap modulo 2^ADDR_W.

Test Plan:
- Stream pass-through: ready_in = 1, drive words 0x0000001..0x0000005 on consecutive cycles → data_out shows the same sequence one cycle later, valid_out continuous, ready_out stays 1.
- Stream stall: hold ready_in = 0 after the first word A and send B → B is captured in the skid register and ready_out = 0 next cycle. Release ready_in → A, then B output on consecutive cycles, then ready_out = 1.
- FIFO ordering: write 0x00524242 ("RBB"), 0x0801027F, 0x10000010 → q = 0x00524242 immediately after the first write and usedw = 3. Three rdreq pulses return the words in order; then empty = 1, usedw = 0.
- FIFO full boundary: write 256 words 0..255 → usedw = 255, full = 1, and word 255 is dropped. Reading all returns 0..254.
- Simultaneous read and write with usedw = 5 → usedw stays 5 and q advances to the second word. rdreq on an empty FIFO → usedw stays 0.
- sclr/reset: with 10 words stored, pulse fifo_sclr together with wrreq → usedw = 0, empty = 1. Assert reset asynchronously mid-stall → valid_out = 0 and ready_out = 1 immediately.
